// File: rtl/bus_timer_if.sv
// CPU-side bus seen by the timer: address/write strobe/write data in,
// registered read data, mux select and interrupt out.
interface bus_timer_if;
  logic [15:0] AD;
  logic [7:0]  DI;
  logic        WE;
  logic [7:0]  DO;
  logic        DO_VALID;
  logic        IRQ;

  modport master (output AD, DI, WE, input DO, DO_VALID, IRQ);
  modport slave  (input AD, DI, WE, output DO, DO_VALID, IRQ);
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped 16-bit prescaled down-counter with one-shot/auto-reload
// modes, registered read port and level interrupt.
module bus_timer #(
  parameter logic [15:0] BASE = 16'hFE00
) (
  input  logic        clk,
  input  logic        RST,
  bus_timer_if.slave  bus
);
  localparam logic [2:0] A_CNTL = 3'd0, A_CNTH = 3'd1, A_RELL = 3'd2, A_RELH = 3'd3,
                         A_CTRL = 3'd4, A_STAT = 3'd5, A_PRE  = 3'd6;

  logic [15:0] count, reload;
  logic [7:0]  rel_lo, snap_h, pcnt, pre, rdata, do_q;
  logic        en, auto_rl, ie, exp_f, do_vld;
  logic        sel, wr, rd, tick, relh_wr, expire;
  logic [2:0]  off;

  assign sel     = (bus.AD[15:3] == BASE[15:3]);
  assign off     = bus.AD[2:0];
  assign wr      = sel & bus.WE;
  assign rd      = sel & ~bus.WE;
  assign tick    = en & (pcnt == pre);
  // A RELH write replaces the whole count state, so it swallows a same-edge tick.
  assign relh_wr = wr & (off == A_RELH);
  assign expire  = tick & ~relh_wr & (count == 16'd0);

  always_comb begin
    rdata = 8'h00;
    case (off)
      A_CNTL:  rdata = count[7:0];
      A_CNTH:  rdata = snap_h;
      A_RELL:  rdata = reload[7:0];
      A_RELH:  rdata = reload[15:8];
      A_CTRL:  rdata = {5'b0, ie, auto_rl, en};
      A_STAT:  rdata = {7'b0, exp_f};
      A_PRE:   rdata = pre;
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      count   <= '0;
      reload  <= '0;
      rel_lo  <= '0;
      snap_h  <= '0;
      pcnt    <= '0;
      pre     <= '0;
      en      <= 1'b0;
      auto_rl <= 1'b0;
      ie      <= 1'b0;
      exp_f   <= 1'b0;
      do_q    <= '0;
      do_vld  <= 1'b0;
    end else begin
      do_vld <= rd;
      if (rd) begin
        do_q <= rdata;
        if (off == A_CNTL) snap_h <= count[15:8];
      end

      if (en) pcnt <= tick ? 8'd0 : pcnt + 8'd1;

      if (tick & ~relh_wr) begin
        if (count != 16'd0) count <= count - 16'd1;
        else if (auto_rl)   count <= reload;
        else                en    <= 1'b0;
      end

      // Expiry set beats a same-edge W1C.
      if (expire)                                        exp_f <= 1'b1;
      else if (wr && off == A_STAT && bus.DI[0])         exp_f <= 1'b0;

      // Bus writes come last so a CTRL write overrides an expiry-induced EN clear.
      if (wr) begin
        case (off)
          A_RELL: rel_lo <= bus.DI;
          A_RELH: begin
            reload <= {bus.DI, rel_lo};
            count  <= {bus.DI, rel_lo};
            pcnt   <= 8'd0;
          end
          A_CTRL: begin
            en      <= bus.DI[0];
            auto_rl <= bus.DI[1];
            ie      <= bus.DI[2];
            if (bus.DI[0] && !en) pcnt <= 8'd0;
          end
          A_PRE: begin
            pre  <= bus.DI;
            pcnt <= 8'd0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.DO       = do_q;
  assign bus.DO_VALID = do_vld;
  assign bus.IRQ      = exp_f & ie;
endmodule
